// File: rtl/iic_pkg.sv
// Shared definitions for the IIC target blocks and the driver that talks to them.
package iic_pkg;

    localparam logic [6:0] IIC_DEV_ADDR = 7'h3C;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK,
        IGNORE
    } iic_state_t;

endpackage

// File: rtl/iic_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: a new level is accepted
// only after it has been seen for FILT consecutive clk cycles.
module iic_glitch_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dout  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_rx_responder.sv
// IIC target exposing an 8-bit register pointer with auto-increment; writes
// appear on reg_we/reg_wdata, reads are taken from reg_rdata.
module iic_rx_responder
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = IIC_DEV_ADDR,
    parameter int unsigned FILT     = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_out_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       scl_f;
    logic       sda_f;
    logic       scl_d;
    logic       sda_d;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_ev;
    logic       stop_ev;

    iic_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [6:0] tx_sr;
    logic [7:0] rx_byte;
    logic       rw;
    logic       mnack;
    logic       rd_inc;

    iic_glitch_filter #(.FILT(FILT)) u_scl_filt (
        .clk  (clk),
        .rstn (rstn),
        .din  (scl_in),
        .dout (scl_f)
    );

    iic_glitch_filter #(.FILT(FILT)) u_sda_filt (
        .clk  (clk),
        .rstn (rstn),
        .din  (sda_in),
        .dout (sda_f)
    );

    assign sda_out = 1'b0;
    assign rx_byte = {rx_sr[6:0], sda_f};

    // START/STOP need SCL high on both sides of the SDA edge, so an SCL and SDA
    // change landing in the same filtered cycle cannot fake a bus condition.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start_ev <= 1'b0;
            stop_ev  <= 1'b0;
        end else begin
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            scl_rise <= scl_f & ~scl_d;
            scl_fall <= ~scl_f & scl_d;
            start_ev <= scl_f & scl_d & sda_d & ~sda_f;
            stop_ev  <= scl_f & scl_d & ~sda_d & sda_f;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            rw         <= 1'b0;
            mnack      <= 1'b0;
            rd_inc     <= 1'b0;
            sda_out_en <= 1'b0;
            reg_we     <= 1'b0;
            busy       <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
        end else begin
            reg_we <= 1'b0;
            rd_inc <= 1'b0;
            // Pointer advances the cycle after a write strobe or a read load.
            if (reg_we || rd_inc) begin
                reg_addr <= reg_addr + 8'd1;
            end

            if (stop_ev) begin
                state      <= IDLE;
                sda_out_en <= 1'b0;
                busy       <= 1'b0;
                bit_cnt    <= '0;
            end else if (start_ev) begin
                state      <= ADDR;
                sda_out_en <= 1'b0;
                busy       <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            rx_sr   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7 && state == REG) begin
                                reg_addr <= rx_byte;
                            end
                            if (bit_cnt == 4'd7 && state == WDATA) begin
                                reg_wdata <= rx_byte;
                                reg_we    <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (rx_sr[7:1] == DEV_ADDR) begin
                                    state      <= ADDR_ACK;
                                    rw         <= rx_sr[0];
                                    sda_out_en <= 1'b1;
                                    busy       <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == REG) begin
                                state      <= REG_ACK;
                                sda_out_en <= 1'b1;
                            end else begin
                                state      <= WDATA_ACK;
                                sda_out_en <= 1'b1;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state      <= RDATA;
                                tx_sr      <= reg_rdata[6:0];
                                sda_out_en <= ~reg_rdata[7];
                                rd_inc     <= 1'b1;
                            end else begin
                                state      <= REG;
                                sda_out_en <= 1'b0;
                            end
                        end
                    end

                    REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            state      <= WDATA;
                            sda_out_en <= 1'b0;
                        end
                    end

                    RDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state      <= MACK;
                                sda_out_en <= 1'b0;
                                bit_cnt    <= '0;
                            end else begin
                                sda_out_en <= ~tx_sr[6];
                                tx_sr      <= {tx_sr[5:0], 1'b0};
                            end
                        end
                    end

                    MACK: begin
                        if (scl_rise) begin
                            mnack <= sda_f;
                        end else if (scl_fall) begin
                            if (mnack) begin
                                state      <= IGNORE;
                                busy       <= 1'b0;
                                sda_out_en <= 1'b0;
                            end else begin
                                state      <= RDATA;
                                tx_sr      <= reg_rdata[6:0];
                                sda_out_en <= ~reg_rdata[7];
                                rd_inc     <= 1'b1;
                            end
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iic_rx_responder.md
IIC_RX_RESPONDER -- requirements
Module: iic_rx_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, the 7-bit target address.
REQ-002 SHALL have parameter FILT, default 3, the number of clk cycles a sampled bus level must stay stable before it is accepted.
REQ-003 SHALL have port clk, input, 1 bit, the system clock.
REQ-004 SHALL have port rstn, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port scl_in, input, 1 bit, the raw bus clock.
REQ-006 SHALL have port sda_in, input, 1 bit, the raw bus data.
REQ-007 SHALL have port sda_out, output, 1 bit, tied to constant 0.
REQ-008 SHALL have port sda_out_en, output, 1 bit; 1 means pull SDA low.
REQ-009 SHALL have port reg_addr, output, 8 bits, the register pointer.
REQ-010 SHALL have port reg_wdata, output, 8 bits, the write data.
REQ-011 SHALL have port reg_we, output, 1 bit, a single-cycle write strobe.
REQ-012 SHALL have port reg_rdata, input, 8 bits, the read data for the current reg_addr.
REQ-013 SHALL have port busy, output, 1 bit, high while the block is addressed.

Function
REQ-014 scl_in and sda_in SHALL each pass through a 2-flop synchronizer and then a FILT-cycle stability filter; all later logic SHALL use only the filtered levels (scl_f, sda_f).
REQ-015 Edges SHALL be detected on scl_f/sda_f, with events registered one cycle after the filter output changes.
REQ-016 START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1.
REQ-017 Data SHALL be sampled on the scl_f rising edge, MSB first; sda_out_en SHALL change only on the cycle after a scl_f falling edge.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE.
REQ-019 START, including a repeated start, SHALL go from any state to ADDR with the bit counter cleared.
REQ-020 STOP SHALL go from any state to IDLE and release SDA.
REQ-021 ADDR SHALL shift in 8 bits. On a match of bits[7:1] with DEV_ADDR it SHALL go to ADDR_ACK and drive SDA low for one SCL period; otherwise it SHALL go to IGNORE (no ACK) until START or STOP.
REQ-022 After ADDR_ACK:
- R/W=0 -> REG.
- R/W=1 -> RDATA.
REQ-023 REG SHALL load the received byte into reg_addr and then ACK (REG_ACK -> WDATA).
REQ-024 For each WDATA byte, reg_wdata SHALL be set and reg_we pulsed for exactly one clk, 1 cycle after the 8th rising edge. reg_addr SHALL increment on the following cycle. The byte SHALL then be ACKed (WDATA_ACK -> WDATA).
REQ-025 On entry to RDATA (the falling edge ending ADDR_ACK or MACK), reg_rdata SHALL be latched into the tx shifter and reg_addr SHALL increment one cycle later.
- sda_out_en = ~bit, MSB first.
REQ-026 MACK SHALL sample the master's ACK bit:
- 0 -> RDATA (next byte).
- 1 (NACK) -> IGNORE, SDA released.
REQ-027 reg_addr SHALL wrap from 8'hFF to 8'h00 without a flag.
REQ-028 A START and a STOP detected in the same cycle are impossible by construction; a START arriving mid-byte SHALL abort that byte with no reg_we.
REQ-029 busy SHALL be 1 from ADDR_ACK entry until IDLE, ADDR, or IGNORE.
REQ-030 The block SHALL never drive SDA high; sda_out_en SHALL be 0 in IDLE, ADDR, REG, WDATA, MACK, and IGNORE.

Reset
REQ-031 While rstn=0, the outputs SHALL be:
- state IDLE.
- sda_out_en=0, reg_we=0, busy=0.
- reg_addr=8'h00, reg_wdata=8'h00.
- synchronizer and filter flops = 1.
REQ-032 Reset mid-transfer SHALL release SDA immediately, and the block SHALL ignore the bus until the next START.

Structure
REQ-033 State encodings and the default DEV_ADDR SHALL live in shared package iic_pkg, which the existing driver also uses.
REQ-034 The synchronizer+filter SHALL be sub-module iic_glitch_filter, instantiated once for SCL and once for SDA.
REQ-035 The target size is roughly 200-300 lines of RTL.

Verification
REQ-036 Write case: START, 0x78, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_we at addr 0x10 with data 0xA5 and at 0x11 with 0x5A; reg_addr ends at 0x12.
REQ-037 Read case: START, 0x78, 0x20, Sr, 0x79, then two bytes with master ACK then NACK, STOP; model returns 0xC3/0x3C -> bus reads 0xC3 then 0x3C; sda_out_en=0 after NACK.
REQ-038 Address mismatch: START, 0x7A, ... -> no ACK, busy=0, no reg_we.
REQ-039 Wrap: write pointer 0xFF with data 0x11, 0x22 -> writes at 0xFF then 0x00.
REQ-040 Glitch: 2-clk low pulse on SCL while high with FILT=3 -> no bit shifted and no state change.
REQ-041 Abort: rstn low during the 4th data bit -> sda_out_en=0 on the next clk; a clean transfer afterwards passes.
